// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and
// the Booth recoding of the {Q[0], q_1} pair.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2'b11 is also a no-op; only ADD and SUB touch the accumulator.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// N-bit combinational add/subtract for the Booth accumulator; wraps modulo 2^N.
module booth_addsub #(
    parameter int N = 9
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic                sub,
    output logic signed [N-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a valid/ready front and back end.
// One Booth step per clock over N = WIDTH+1 extended bits handles both signed and unsigned operands.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N) + 1;

    state_t state_q, state_d;

    logic signed [N-1:0]  m_q, m_d;
    logic signed [N-1:0]  a_q, a_d;
    logic [N-1:0]         q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [1:0]           booth_op;
    logic signed [N-1:0]  sum;
    logic signed [N-1:0]  a_new;
    logic signed [N-1:0]  a_sh;
    logic [N-1:0]         q_sh;
    logic                 q1_sh;
    logic                 last_step;

    assign booth_op  = {q_q[0], q1_q};
    assign last_step = (cnt_q == CW'(N - 1));

    booth_addsub #(.N(N)) u_addsub (
        .a   (a_q),
        .b   (m_q),
        .sub (booth_op == BOOTH_SUB),
        .sum (sum)
    );

    // Conditional add/sub followed by an arithmetic shift of {A, Q, q_1}.
    always_comb begin
        a_new = ((booth_op == BOOTH_ADD) || (booth_op == BOOTH_SUB)) ? sum : a_q;
        {a_sh, q_sh, q1_sh} = {a_new[N-1], a_new, q_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || (state_q == DONE);
    end

    // Datapath next-state; operands are captured only on the accept edge.
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if ((state_q == IDLE) && in_valid) begin
            m_d   = {op_signed & op_a[WIDTH-1], op_a};
            q_d   = {op_signed & op_b[WIDTH-1], op_b};
            a_d   = '0;
            q1_d  = 1'b0;
            cnt_d = '0;
        end else if (state_q == CALC) begin
            a_d   = a_sh;
            q_d   = q_sh;
            q1_d  = q1_sh;
            cnt_d = cnt_q + CW'(1);
            // The two top bits of {A, Q} are pure sign extension of the result.
            if (last_step) begin
                product_d = {a_sh[N-3:0], q_sh};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH = 4, 8 and 13: directed corner cases on the
// 8-bit instance, then randomized transactions on all three against an arithmetic reference.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv   = '0;
    logic [2:0]  ordy = '0;
    logic [12:0] opa  = '0;
    logic [12:0] opb  = '0;
    logic        osg  = 1'b0;
    logic [2:0]  irdy, ovld, bsy;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [25:0] p13;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .op_a(opa[3:0]), .op_b(opb[3:0]), .op_signed(osg),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .product(p4), .busy(bsy[0])
    );

    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .op_a(opa[7:0]), .op_b(opb[7:0]), .op_signed(osg),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .product(p8), .busy(bsy[1])
    );

    booth_mult_seq #(.WIDTH(13)) u13 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .op_a(opa), .op_b(opb), .op_signed(osg),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .product(p13), .busy(bsy[2])
    );

    function automatic int wid(int d);
        return (d == 0) ? 4 : ((d == 1) ? 8 : 13);
    endfunction

    function automatic logic [25:0] prod(int d);
        case (d)
            0:       return 26'(p4);
            1:       return 26'(p8);
            default: return p13;
        endcase
    endfunction

    // Interpret operands as integers of width w, multiply, keep 2w bits.
    function automatic logic [25:0] ref_prod(int w, logic [12:0] a, logic [12:0] b, bit s);
        longint va, vb, wmask, pmask;
        wmask = (longint'(1) << w) - 1;
        pmask = (longint'(1) << (2 * w)) - 1;
        va = longint'(a) & wmask;
        vb = longint'(b) & wmask;
        if (s && (((va >> (w - 1)) & 1) != 0)) va = va - (longint'(1) << w);
        if (s && (((vb >> (w - 1)) & 1) != 0)) vb = vb - (longint'(1) << w);
        return 26'((va * vb) & pmask);
    endfunction

    task automatic chk(string tag, logic [25:0] obs, logic [25:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d; returns with the instance back in IDLE.
    task automatic transact(int d, logic [12:0] a, logic [12:0] b, bit s, logic [25:0] want,
                            int pre, int stall, bit keep_rdy, bit noise);
        int n;
        int lat;
        n = wid(d) + 1;
        repeat (pre) @(negedge clk);
        ordy[d] = keep_rdy;
        opa = a;
        opb = b;
        osg = s;
        iv[d] = 1'b1;
        chk("in_ready_idle", 26'(irdy[d]), 26'h1);
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ovld[d] && lat < n + 4) begin
            chk("in_ready_calc", 26'(irdy[d]), 26'h0);
            chk("busy_calc", 26'(bsy[d]), 26'h1);
            if (noise) begin
                iv[d] = 1'($urandom);
                opa   = 13'($urandom);
                opb   = 13'($urandom);
                osg   = 1'($urandom);
            end
            @(negedge clk);
            iv[d] = 1'b0;
            lat++;
        end
        chk("latency", 26'(lat), 26'(n));
        chk("product", prod(d), want);
        chk("busy_done", 26'(bsy[d]), 26'h1);
        if (!keep_rdy) begin
            repeat (stall) @(negedge clk);
            chk("out_valid_hold", 26'(ovld[d]), 26'h1);
            chk("product_hold", prod(d), want);
            ordy[d] = 1'b1;
        end
        @(negedge clk);
        ordy[d] = 1'b0;
        chk("out_valid_drop", 26'(ovld[d]), 26'h0);
        chk("in_ready_back", 26'(irdy[d]), 26'h1);
        chk("product_idle", prod(d), want);
    endtask

    initial begin
        logic [12:0] a, b, mask;
        bit          s;
        int          w;

        // Reset state on all three instances.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", 26'(irdy[d]), 26'h1);
            chk("rst_out_valid", 26'(ovld[d]), 26'h0);
            chk("rst_busy", 26'(bsy[d]), 26'h0);
            chk("rst_product", prod(d), 26'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed cases on the 8-bit instance.
        transact(1, 13'h003, 13'h0FB, 1'b1, 26'hFFF1, 0, 3, 1'b0, 1'b0);
        transact(1, 13'h080, 13'h080, 1'b1, 26'h4000, 1, 0, 1'b0, 1'b0);
        transact(1, 13'h080, 13'h07F, 1'b1, 26'hC080, 0, 1, 1'b0, 1'b0);
        transact(1, 13'h000, 13'h0FF, 1'b1, 26'h0000, 0, 0, 1'b0, 1'b0);
        transact(1, 13'h0FF, 13'h0FF, 1'b0, 26'hFE01, 0, 2, 1'b0, 1'b0);
        transact(1, 13'h0C8, 13'h003, 1'b0, 26'h0258, 0, 0, 1'b0, 1'b0);
        transact(1, 13'h0C8, 13'h003, 1'b1, 26'hFF58, 0, 0, 1'b0, 1'b0);

        // Back-to-back with out_ready held high and in_valid noise during CALC.
        transact(1, 13'h007, 13'h006, 1'b0, 26'h002A, 0, 0, 1'b1, 1'b1);
        transact(1, 13'h009, 13'h0FE, 1'b1, 26'hFFEE, 0, 0, 1'b1, 1'b1);

        // Asynchronous reset four steps into CALC.
        opa = 13'h055;
        opb = 13'h033;
        osg = 1'b0;
        iv[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 26'(bsy[1]), 26'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 26'(ovld[1]), 26'h0);
        chk("abort_busy", 26'(bsy[1]), 26'h0);
        chk("abort_in_ready", 26'(irdy[1]), 26'h1);
        chk("abort_product", prod(1), 26'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort_no_output", 26'(ovld[1]), 26'h0);
        transact(1, 13'h00C, 13'h00C, 1'b0, 26'h0090, 0, 0, 1'b0, 1'b0);

        // Randomized regression across widths, modes and handshake stalls.
        for (int d = 0; d < 3; d++) begin
            w = wid(d);
            mask = 13'((32'd1 << w) - 1);
            for (int i = 0; i < 30; i++) begin
                a = 13'($urandom) & mask;
                b = 13'($urandom) & mask;
                case ($urandom_range(0, 5))
                    0: a = mask;
                    1: a = 13'(32'd1 << (w - 1));
                    2: b = 13'(32'd1 << (w - 1));
                    3: b = '0;
                    default: ;
                endcase
                s = 1'($urandom);
                transact(d, a, b, s, ref_prod(w, a, b, s), $urandom_range(0, 3),
                         $urandom_range(0, 4), 1'($urandom), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with integrated controller, counter and add/sub unit. Supports signed and unsigned operands of WIDTH bits, selected per operation. Uses valid/ready handshakes on input and output, so it drops into the datapath without an external controller. Intended as the general-width successor to the fixed 5-bit Booth datapath.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
N (localparam), WIDTH+1, internal width and iteration count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept (high only in IDLE)
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
out_valid  output  1  product valid (high only in DONE)
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result, registered
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, product=0, out_valid=0, busy=0, in_ready=1, all internal registers 0. Reset mid-CALC or mid-DONE aborts with no output.
- Operand extension at accept: M = {op_signed ? op_a[W-1] : 0, op_a}; Q = {op_signed ? op_b[W-1] : 0, op_b}; both N bits.
- IDLE: in_ready=1. On edge with in_valid=1: load M, Q, A=0, q_1=0, cnt=0 -> CALC. in_valid=0: stay.
- CALC (one Booth step per clock): {Q[0],q_1}=01: A=A+M; 10: A=A-M; 00/11: no op. Then arithmetic shift right of {A,Q,q_1} by 1, keeping A's sign. Add/sub is N bits, wraps modulo 2^N. cnt increments; on the step with cnt==N-1, product <= lower 2*WIDTH bits of the shifted {A,Q} -> DONE.
- Latency: out_valid rises exactly N cycles after the accept edge (9 for WIDTH=8).
- DONE: out_valid=1, product stable. On edge with out_ready=1 -> IDLE. Earliest next accept is the following edge.
- Inputs are ignored outside their state: in_valid/operands outside IDLE, out_ready outside DONE. Operand changes during CALC do not affect the result.
- product holds its last value in IDLE until the next DONE load.
- Range: signed results lie in [-(2^(W-1))*(2^(W-1)-1), 2^(2W-2)] and unsigned results in [0, (2^W-1)^2]; all fit in 2*WIDTH bits. No overflow flag.
- cnt width: $clog2(N)+1 bits. No wrap occurs within one operation.

Decomposition:
- Package booth_pkg: state enum {IDLE, CALC, DONE} and Booth op-code constants (NOP, ADD, SUB) from {Q[0],q_1}.
- Sub-module booth_addsub, parametrised N: inputs a, b, sub; output sum. Purely combinational; instantiated once.
- FSM, counter and shift register stay in booth_mult_seq.

Test Plan:
- WIDTH=8, signed, 3 x -5: accept, then out_valid exactly 9 cycles later with product=16'hFFF1; hold out_ready=0 for 3 cycles -> product stable and out_valid held.
- Signed corner -128 x -128 -> 16'h4000. Signed -128 x 127 -> 16'hC080. Signed 0 x -1 -> 16'h0000.
- Unsigned 255 x 255 -> 16'hFE01. Unsigned 200 x 3 -> 16'h0258. Same bits signed (-56 x 3) -> 16'hFF58.
- Back-to-back with out_ready=1 constantly: accept 7 x 6, then 9 x -2 signed. Results 16'h002A then 16'hFFEE. in_ready=0 throughout CALC/DONE; in_valid pulses during CALC are ignored.
- rst asserted asynchronously mid-CALC (cnt=4): outputs go to reset values immediately, with no out_valid. The next operation, 12 x 12 unsigned, gives 16'h0090.
- Random regression (WIDTH=4, 8, 13; both modes; random handshake stalls) against a reference model: exact product and latency N on every transaction.
